seg7_scan_decoder: RTL and testbench
====================================

Name: seg7_scan_decoder

Overview:
- Receive side of the 4-digit seven-segment display path.
- Watches the time-multiplexed anode-select and segment lines that a scanned display driver produces, and recovers the four BCD digits x0..x3.
- Presents them as one coherent frame with per-digit error flags.
- Used as a display monitor and as a loop-back checker against the BCD-to-7seg encoder.

Parameters:
- SETTLE, 4, consecutive clock cycles an anode selection must be stable before segments are sampled (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- an  input  4  anode select, active-low, one-hot-low; an[i]=0 selects digit i.
- seg  input  7  segment lines, active-low; seg[0]=a … seg[6]=g.
- d0  output  4  decoded digit 0 (x0), frame-coherent.
- d1  output  4  decoded digit 1 (x1).
- d2  output  4  decoded digit 2 (x2).
- d3  output  4  decoded digit 3 (x3).
- err  output  4  err[i]=1 means the digit i pattern in the last frame was not 0-9.
- frame_done  output  1  one-cycle pulse when d0..d3/err update.
- valid  output  1  sticky; set with the first frame_done after reset.

Behaviour:
- Reset (async, rst=1): d0..d3=4'h0, err=4'h0, frame_done=0, valid=0. Internal state cleared: stability counter, previous-anode register, sampled flag, seen mask, shadow digits.
- Legal select: an has exactly one bit low (4'b1110, 4'b1101, 4'b1011, 4'b0111).
- Illegal select: all-high (blanking) or multiple low.
  - Clears the stability counter and the sampled flag.
  - Never samples; it does not clear the seen mask.
- Stability counter:
  - Counts consecutive cycles in which an is legal and equal to its value on the previous cycle.
  - Any change of an restarts the count at 1 if the new value is legal, else 0.
  - Saturates at SETTLE.
- Capture:
  - Occurs on the clock edge where the count reaches SETTLE and the sampled flag is clear.
  - Exactly one capture per dwell; the sampled flag blocks re-capture until an changes.
  - With SETTLE=1, capture happens on the first edge a legal value is present.
- Decode table (active-low seg[6:0] -> value):
  - 7'h40->0, 7'h79->1, 7'h24->2, 7'h30->3, 7'h19->4
  - 7'h12->5, 7'h02->6, 7'h78->7, 7'h00->8, 7'h10->9
  - Any other pattern, including 7'h7F (blank), -> shadow digit 4'hF with shadow err bit set. A valid decode clears that shadow err bit.
- Seen mask:
  - The capture of digit i sets seen[i].
  - Re-capturing an already-seen digit overwrites its shadow value (latest wins).
- Frame commit:
  - Happens on the edge where a capture makes seen==4'hF.
  - On that edge: d0..d3 and err load from shadow (including the value just captured), frame_done=1 for exactly the following cycle, valid=1, seen mask cleared.
- Latency: frame_done and outputs are visible in the cycle after the completing capture edge.
- Outputs hold between commits. A frame never commits partially.
- Scan order is irrelevant; any order covering all four digits completes a frame.
- Reset asserted mid-frame: partial shadow data is discarded. The first frame after reset needs all four digits again.

Decomposition:
- Shared package holds:
  - SEG_* localparams for the ten active-low patterns;
  - SEG_BLANK = 7'h7F;
  - DIG_INVALID = 4'hF;
  - the anode one-hot-low constants.
- The same constants serve the BCD-to-7seg encoder, so both ends share one table.
- One natural combinational sub-module: seg7_to_bcd (seg in -> 4-bit value + invalid flag).
- Scan tracking, capture and frame commit stay in the top.

Test Plan:
- Reset check: rst=1 mid-run -> d0..d3=0, err=0, valid=0, frame_done=0 immediately, independent of clk.
- Normal scan, SETTLE=4, 8 cycles per digit: an 1110/1101/1011/0111 with patterns for 3,7,0,9 -> one frame_done, d0=3, d1=7, d2=0, d3=9, err=0, valid=1.
- Glitch rejection: an 1110 for only 3 cycles with pattern 7'h24, then 1101 -> no capture of digit 0, no frame_done until digit 0 dwells ≥4 cycles.
- Invalid pattern: digit 2 shows 7'h7F and others show valid patterns -> d2=4'hF, err=4'b0100, remaining digits correct.
- Illegal select and order: an=4'b1100 for 10 cycles, then the order 3,1,0,2 showing 9,8,1,5 on x3,x1,x0,x2 -> no sample during 1100; frame gives d0=1, d1=8, d2=5, d3=9.
- Reset mid-frame: digits 0-2 captured, rst pulse, then full scan of 2,2,2,2 -> only one frame_done (post-reset), all d=2.
- Random loop-back: 200 random x0..x3 through the encoder plus a scan driver -> every committed frame equals the applied inputs; err set only for inputs 10-15.

Source files
------------

// File: rtl/seg7_scan_decoder_pkg.sv
// seg7_scan_decoder_pkg: seven-segment pattern table and anode constants shared by encoder and decoder
package seg7_scan_decoder_pkg;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] DIG_INVALID = 4'hF;
  localparam logic [3:0] AN_D0 = 4'b1110;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D3 = 4'b0111;
  typedef struct packed {
    logic       legal;
    logic [1:0] idx;
  } sel_t;
  function automatic sel_t decode_an(input logic [3:0] an);
    return an == AN_D0 ? '{1'b1, 2'd0} :
           an == AN_D1 ? '{1'b1, 2'd1} :
           an == AN_D2 ? '{1'b1, 2'd2} :
           an == AN_D3 ? '{1'b1, 2'd3} : '{1'b0, 2'd0};
  endfunction
endpackage

// File: rtl/seg7_scan_decoder_seg7_to_bcd.sv
// seg7_to_bcd: active-low segment pattern to BCD value with invalid flag
module seg7_to_bcd
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       invalid
);
  always_comb begin
    invalid = 1'b0;
    case (seg)
      SEG_0:   value = 4'd0;
      SEG_1:   value = 4'd1;
      SEG_2:   value = 4'd2;
      SEG_3:   value = 4'd3;
      SEG_4:   value = 4'd4;
      SEG_5:   value = 4'd5;
      SEG_6:   value = 4'd6;
      SEG_7:   value = 4'd7;
      SEG_8:   value = 4'd8;
      SEG_9:   value = 4'd9;
      default: begin
        value   = DIG_INVALID;
        invalid = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers four BCD digits from a scanned seven-segment bus into coherent frames
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int unsigned SETTLE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] an,
  input  logic [6:0] seg,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic [3:0] err,
  output logic       frame_done,
  output logic       valid
);
  localparam logic [7:0] SET = 8'(SETTLE);
  logic [7:0] cnt, cnt_n;
  logic [3:0] prev_an, seen, seen_n, sh_err, err_n;
  logic [3:0][3:0] sh, sh_n;
  logic sampled, sampled_n, same, cap, commit, invalid;
  logic [3:0] value;
  sel_t sel;
  seg7_to_bcd u_dec (.seg(seg), .value(value), .invalid(invalid));
  // a capture is allowed once per dwell; any change of an re-arms it
  always_comb begin
    sel = decode_an(an);
    same = an == prev_an;
    cnt_n = !sel.legal ? 8'd0 : !same ? 8'd1 : cnt >= SET ? SET : cnt + 8'd1;
    cap = sel.legal && cnt_n == SET && !(sampled && same);
    sampled_n = cap ? 1'b1 : (sel.legal && same) ? sampled : 1'b0;
    seen_n = cap ? seen | (4'b1 << sel.idx) : seen;
    commit = cap && &seen_n;
    sh_n = sh;
    err_n = sh_err;
    for (int i = 0; i < 4; i++) begin
      sh_n[i] = (cap && sel.idx == 2'(i)) ? value : sh[i];
      err_n[i] = (cap && sel.idx == 2'(i)) ? invalid : sh_err[i];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      prev_an <= '0;
      sampled <= 1'b0;
      seen <= '0;
      sh <= '0;
      sh_err <= '0;
      {d0, d1, d2, d3, err} <= '0;
      frame_done <= 1'b0;
      valid <= 1'b0;
    end else begin
      cnt <= cnt_n;
      prev_an <= an;
      sampled <= sampled_n;
      seen <= commit ? 4'h0 : seen_n;
      sh <= sh_n;
      sh_err <= err_n;
      frame_done <= commit;
      if (commit) begin
        {d3, d2, d1, d0} <= sh_n;
        err <= err_n;
        valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed and random scans with a frame scoreboard for seg7_scan_decoder
module tb_seg7_scan_decoder;
  typedef struct packed {
    logic [3:0] err, d3, d2, d1, d0;
  } frame_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] an = 4'hF;
  logic [6:0] seg = 7'h7F;
  logic [3:0] d0, d1, d2, d3, err;
  logic frame_done, valid;
  int total = 0, bad = 0, frames = 0;
  frame_t q[$];
  always #5 clk = ~clk;
  seg7_scan_decoder #(.SETTLE(4)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .err(err), .frame_done(frame_done), .valid(valid)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction
  function automatic frame_t expf(input logic [15:0] v);
    logic [3:0] e, x;
    logic [15:0] d;
    for (int i = 0; i < 4; i++) begin
      x = v[4*i+:4];
      e[i] = x > 4'd9;
      d[4*i+:4] = x > 4'd9 ? 4'hF : x;
    end
    return {e, d};
  endfunction
  always @(negedge clk) begin
    frame_t e;
    if (!rst && frame_done) begin
      frames++;
      chk("frame_expected", q.size() > 0, 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("frame", {err, d3, d2, d1, d0}, e);
        chk("frame_valid", valid, 1);
      end
    end
  end
  task automatic show(input logic [1:0] idx, input logic [6:0] pat, input int n);
    an = ~(4'b1 << idx);
    seg = pat;
    repeat (n) @(negedge clk);
  endtask
  task automatic blank(input int n);
    an = 4'hF;
    seg = 7'h7F;
    repeat (n) @(negedge clk);
  endtask
  task automatic scan(input logic [15:0] v, input logic [7:0] ord, input int dw);
    logic [1:0] idx;
    q.push_back(expf(v));
    for (int k = 0; k < 4; k++) begin
      idx = ord[2*k+:2];
      show(idx, enc(v[4*idx+:4]), dw);
    end
    blank(2);
    chk("q_drained", q.size(), 0);
    chk("fd_low", frame_done, 0);
    chk("valid_set", valid, 1);
  endtask
  initial begin
    int f0;
    logic [15:0] v;
    logic [7:0] ord;
    logic [1:0] r;
    repeat (3) @(negedge clk);
    chk("reset_out", {valid, frame_done, err, d3, d2, d1, d0}, 0);
    rst = 1'b0;
    blank(2);
    chk("valid_before_frame", valid, 0);
    scan(16'h9073, 8'hE4, 8);
    f0 = frames;
    q.push_back(expf(16'h3212));
    show(0, 7'h24, 3);
    show(1, enc(1), 8);
    show(2, enc(2), 8);
    show(3, enc(3), 8);
    chk("glitch_no_frame", frames, f0);
    show(0, 7'h24, 8);
    blank(2);
    chk("glitch_q_drained", q.size(), 0);
    scan(16'h4F21, 8'hE4, 8);
    f0 = frames;
    an = 4'b1100;
    seg = enc(8);
    repeat (10) @(negedge clk);
    chk("illegal_no_frame", frames, f0);
    scan(16'h9581, 8'h87, 8);
    show(0, enc(5), 8);
    show(1, enc(5), 8);
    show(2, enc(5), 8);
    #2 rst = 1'b1;
    #1 chk("async_reset_out", {valid, frame_done, err, d3, d2, d1, d0}, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("valid_after_reset", valid, 0);
    f0 = frames;
    blank(1);
    scan(16'h2222, 8'h1B, 8);
    chk("one_frame_after_reset", frames, f0 + 1);
    for (int n = 0; n < 200; n++) begin
      v = 16'($urandom);
      r = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) ord[2*k+:2] = r + 2'(k);
      scan(v, ord, $urandom_range(4, 9));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
